// File: rtl/cluster_rst_seq_if.sv
// Bundle between chip clock/reset control and the cluster reset sequencer.
// The sequencer takes the master modport; the chip control side takes slave.
interface cluster_rst_seq_if #(
    parameter int NUM_CLUSTERS = 4
);
    logic                    wrm_rst_req;
    logic                    dbg_init_req;
    logic [NUM_CLUSTERS-1:0] cken_mask;
    logic [NUM_CLUSTERS-1:0] cluster_cken;
    logic                    grst_l;
    logic                    gdbginit_l;
    logic                    seq_busy;
    logic                    seq_done;

    modport master (
        input  wrm_rst_req,
        input  dbg_init_req,
        input  cken_mask,
        output cluster_cken,
        output grst_l,
        output gdbginit_l,
        output seq_busy,
        output seq_done
    );

    modport slave (
        output wrm_rst_req,
        output dbg_init_req,
        output cken_mask,
        input  cluster_cken,
        input  grst_l,
        input  gdbginit_l,
        input  seq_busy,
        input  seq_done
    );
endinterface

// File: rtl/cluster_rst_seq.sv
// Cluster clock-enable / global reset sequencer: staggered clock ramp, reset hold,
// then warm-reset and debug-init service. CLUSTER_RST_SEQ_REQ_SYNC_EN synchronizes async request levels.
module cluster_rst_seq #(
    parameter int NUM_CLUSTERS = 4,
    parameter int CKEN_STAGGER = 2,
    parameter int RST_HOLD     = 16
) (
    input  logic              gclk,
    input  logic              arst_l,
    cluster_rst_seq_if.master bus
);
    localparam int MAX_NS  = (NUM_CLUSTERS > CKEN_STAGGER) ? NUM_CLUSTERS : CKEN_STAGGER;
    localparam int MAX_CNT = (MAX_NS > RST_HOLD) ? MAX_NS : RST_HOLD;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0]        STAG_LD   = CNT_W'(CKEN_STAGGER - 1);
    localparam logic [CNT_W-1:0]        HOLD_LD   = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0]        LAST_IDX  = CNT_W'(NUM_CLUSTERS - 1);
    localparam logic [CNT_W-1:0]        CNT_ONE   = CNT_W'(1);
    localparam logic [NUM_CLUSTERS-1:0] CKEN_ALL  = '1;
    localparam logic [NUM_CLUSTERS-1:0] CKEN_BIT0 = NUM_CLUSTERS'(1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RAMP = 3'd1,
        HOLD = 3'd2,
        RUN  = 3'd3,
        WRST = 3'd4,
        DBG  = 3'd5
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        idx_nxt;
    logic [NUM_CLUSTERS-1:0] cken_q, cken_d;
    logic                    grst_q, grst_d;
    logic                    gdbg_q, gdbg_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    wrm_evt, dbg_evt;
    logic                    wrm_req_q, dbg_req_q;

`ifdef CLUSTER_RST_SEQ_REQ_SYNC_EN
    // Two flops to resolve metastability, third flop for rising-edge detection.
    logic [2:0] wrm_sync_q;
    logic [2:0] dbg_sync_q;

    always_ff @(posedge gclk or negedge arst_l) begin
        if (!arst_l) begin
            wrm_sync_q <= '0;
            dbg_sync_q <= '0;
        end else begin
            wrm_sync_q <= {wrm_sync_q[1:0], bus.wrm_rst_req};
            dbg_sync_q <= {dbg_sync_q[1:0], bus.dbg_init_req};
        end
    end

    assign wrm_evt = wrm_sync_q[1] & ~wrm_sync_q[2];
    assign dbg_evt = dbg_sync_q[1] & ~dbg_sync_q[2];
`else
    assign wrm_evt = bus.wrm_rst_req;
    assign dbg_evt = bus.dbg_init_req;
`endif

    assign idx_nxt = idx_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (NUM_CLUSTERS == 1) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    state_d = RAMP;
                    cnt_d   = STAG_LD;
                end
            end
            RAMP: begin
                if (cnt_q == '0) begin
                    idx_d = idx_nxt;
                    if (idx_nxt == LAST_IDX) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LD;
                    end else begin
                        cnt_d = STAG_LD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            HOLD, WRST: begin
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - CNT_ONE;
            end
            RUN: begin
                if (wrm_req_q) begin
                    state_d = WRST;
                    cnt_d   = HOLD_LD;
                end else if (dbg_req_q) begin
                    state_d = DBG;
                    cnt_d   = HOLD_LD;
                end
            end
            DBG: begin
                // A warm reset supersedes an in-flight debug init and restarts the hold.
                if (wrm_req_q) begin
                    state_d = WRST;
                    cnt_d   = HOLD_LD;
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the transition edge.
    always_comb begin
        cken_d = '0;
        case (state_d)
            RAMP:             cken_d = cken_q | (CKEN_BIT0 << idx_d);
            HOLD, WRST, DBG:  cken_d = CKEN_ALL;
            RUN:              cken_d = bus.cken_mask;
            default:          cken_d = '0;
        endcase
        grst_d = (state_d == RUN) || (state_d == DBG);
        gdbg_d = (state_d == RUN);
        busy_d = (state_d != RUN);
        done_d = (state_d == RUN) && (state_q != RUN);
    end

    always_ff @(posedge gclk or negedge arst_l) begin
        if (!arst_l) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            cken_q    <= '0;
            grst_q    <= 1'b0;
            gdbg_q    <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            wrm_req_q <= 1'b0;
            dbg_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            cken_q    <= cken_d;
            grst_q    <= grst_d;
            gdbg_q    <= gdbg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wrm_req_q <= wrm_evt;
            dbg_req_q <= dbg_evt;
        end
    end

    assign bus.cluster_cken = cken_q;
    assign bus.grst_l       = grst_q;
    assign bus.gdbginit_l   = gdbg_q;
    assign bus.seq_busy     = busy_q;
    assign bus.seq_done     = done_q;
endmodule
